parking_occupancy: RTL and testbench
====================================

Name: parking_occupancy

Overview:
- Downstream consumer of the entry sensor FSM's `y` pulse and of the matching exit FSM's pulse.
- Tracks the number of cars in the lot and flags full/empty.
- Drives the entry barrier through a small request/open/timeout state machine.
- Latches sticky error flags for inconsistent sensor events.

Parameters:
- CAPACITY, 8, number of parking spaces (1..2**CNT_W-1).
- CNT_W, 4, width of occupancy counter.
- GATE_TIMEOUT, 100, clk cycles the barrier stays open waiting for a car.
- TMR_W, 7, width of gate timer (must hold GATE_TIMEOUT).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- car_in  input  1  entry-complete indication from entry FSM; synchronous to clk; may stay high >1 cycle.
- car_out  input  1  exit-complete indication from exit FSM; same rules as car_in.
- entry_req  input  1  driver pressed entry button (level).
- clear_err  input  1  synchronous clear of sticky error flags.
- count  output  CNT_W  cars currently inside.
- free  output  CNT_W  CAPACITY - count.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- gate_open  output  1  entry barrier raise command.
- gate_timeout  output  1  one-cycle pulse when barrier closes with no car entering.
- overflow_err  output  1  sticky: entry attempted beyond capacity.
- underflow_err  output  1  sticky: exit seen with lot empty.

Behaviour:

Reset (reset=0, async):
- count=0, free=CAPACITY, empty=1, full=0.
- gate_open=0, gate_timeout=0, both errors=0.
- Gate FSM enters IDLE, timer=0, edge registers=0.
- Reset mid-operation (gate open, count nonzero) discards everything immediately.

Edge detection:
- Registered copies in_q/out_q.
- in_ev = car_in & ~in_q; out_ev = car_out & ~out_q.
- Each high level counts exactly once.
- count updates on the clk edge that samples the event, so it is visible 1 cycle after car_in/car_out first goes high.

Counter:
- in_ev only: if count<CAPACITY then count+1, else count unchanged and overflow_err<=1.
- out_ev only: if count>0 then count-1, else count unchanged and underflow_err<=1.
- in_ev and out_ev in the same cycle: count unchanged, no error, including at full and at empty.
- No wrap-around is ever permitted.
- full, empty and free are combinational from registered count.

Errors:
- Sticky until clear_err=1 sampled.
- If clear_err and a new error occur in the same cycle, the new error wins (flag stays 1).

Gate FSM (states IDLE, OPEN, WAIT_CLR):
- IDLE: gate_open=0. If entry_req=1 and full=0, go to OPEN and load timer=0. If entry_req=1 while full, stay IDLE.
- OPEN: gate_open=1; timer increments each cycle.
  - On in_ev, go to WAIT_CLR; count increments as normal.
  - Else if timer==GATE_TIMEOUT-1, go to WAIT_CLR and pulse gate_timeout for 1 cycle, coincident with the transition edge.
  - out_ev while OPEN is counted normally and does not affect the FSM.
- WAIT_CLR: gate_open=0. Go to IDLE when entry_req=0, so a held button cannot reopen the gate.

Other counter rules:
- in_ev while IDLE (tailgating) is still counted; overflow applies.
- gate_open is a registered output: high the cycle after the transition into OPEN, low the cycle after leaving OPEN.

Test Plan:
- Hold reset=0 with random inputs, release -> count=0, free=8, empty=1, gate_open=0, errors 0.
- Eight car_in pulses, each 3 cycles high -> count steps 1..8 once per pulse; full=1 at 8, free=0. Ninth pulse -> count stays 8, overflow_err=1. clear_err -> overflow_err=0.
- At count=8, assert car_in and car_out rising together -> count stays 8, no error. At count=0, car_out alone -> underflow_err=1, count 0.
- entry_req=1 at count=3 -> gate_open=1 next cycle; car_in pulse 5 cycles later -> gate_open=0, count=4, gate_timeout never pulses. Keep entry_req=1 -> gate stays closed until entry_req drops then rises again.
- entry_req pulse, no car -> gate_open high exactly GATE_TIMEOUT (100) cycles; gate_timeout pulses once; count unchanged. entry_req while full=1 -> gate_open remains 0.
- Gate OPEN with count=5, drive reset=0 mid-cycle -> outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/parking_occupancy.sv
// Parking lot occupancy tracker: counts entry/exit events, flags full/empty and sticky
// sensor-consistency errors, and sequences the entry barrier (request/open/timeout).
module parking_occupancy #(
  parameter int unsigned CAPACITY     = 8,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned GATE_TIMEOUT = 100,
  parameter int unsigned TMR_W        = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_in,
  input  logic             car_out,
  input  logic             entry_req,
  input  logic             clear_err,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] free,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             gate_timeout,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam logic [CNT_W-1:0] Cap      = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TmrLast  = TMR_W'(GATE_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StOpen, StWaitClr} gate_state_e;

  gate_state_e      state_q;
  logic [TMR_W-1:0] timer_q;
  logic             in_q, out_q;
  logic             in_ev, out_ev;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  assign in_ev  = car_in & ~in_q;
  assign out_ev = car_out & ~out_q;

  assign count         = count_q;
  assign free          = Cap - count_q;
  assign full          = (count_q == Cap);
  assign empty         = (count_q == '0);
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

  // Simultaneous entry and exit cancel out, even at the full/empty limits.
  always_comb begin
    count_d = count_q;
    ovf_d   = clear_err ? 1'b0 : ovf_q;
    unf_d   = clear_err ? 1'b0 : unf_q;
    if (in_ev && !out_ev) begin
      if (count_q < Cap) count_d = count_q + CNT_W'(1);
      else               ovf_d   = 1'b1;
    end else if (out_ev && !in_ev) begin
      if (count_q != '0) count_d = count_q - CNT_W'(1);
      else               unf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q    <= 1'b0;
      out_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      in_q    <= car_in;
      out_q   <= car_out;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      gate_open    <= 1'b0;
      gate_timeout <= 1'b0;
    end else begin
      gate_timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (entry_req && !full) begin
            state_q   <= StOpen;
            timer_q   <= '0;
            gate_open <= 1'b1;
          end
        end
        StOpen: begin
          timer_q <= timer_q + TMR_W'(1);
          if (in_ev) begin
            state_q   <= StWaitClr;
            gate_open <= 1'b0;
          end else if (timer_q == TmrLast) begin
            state_q      <= StWaitClr;
            gate_open    <= 1'b0;
            gate_timeout <= 1'b1;
          end
        end
        StWaitClr: begin
          // Button must be released before the gate can be requested again.
          if (!entry_req) state_q <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_occupancy.sv
// Directed testbench for parking_occupancy: counting, limits, errors, gate FSM, async reset.
module tb_parking_occupancy;

  logic       clk = 1'b0;
  logic       reset;
  logic       car_in, car_out, entry_req, clear_err;
  logic [3:0] count, free;
  logic       full, empty, gate_open, gate_timeout, overflow_err, underflow_err;

  int n_cmp = 0;
  int n_err = 0;

  parking_occupancy #(
    .CAPACITY(8), .CNT_W(4), .GATE_TIMEOUT(100), .TMR_W(7)
  ) dut (
    .clk(clk), .reset(reset), .car_in(car_in), .car_out(car_out),
    .entry_req(entry_req), .clear_err(clear_err), .count(count), .free(free),
    .full(full), .empty(empty), .gate_open(gate_open), .gate_timeout(gate_timeout),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      car_in    = 1'($urandom_range(0, 1));
      car_out   = 1'($urandom_range(0, 1));
      entry_req = 1'($urandom_range(0, 1));
      clear_err = 1'($urandom_range(0, 1));
      tick();
    end
    car_in = 0; car_out = 0; entry_req = 0; clear_err = 0;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({count, free, empty, full, gate_open, gate_timeout, overflow_err, underflow_err}
        !== {4'd0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: count=%0d free=%0d empty=%b full=%b gate=%b to=%b ovf=%b unf=%b, want 0 8 1 0 0 0 0 0",
               count, free, empty, full, gate_open, gate_timeout, overflow_err, underflow_err);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      car_in = 1'b1;
      tick();
      n_cmp++;
      if (count !== 4'(i)) begin
        n_err++; $display("FAIL fill_step: count=%0d want %0d", count, i);
      end
      tick(); tick();
      n_cmp++;
      if (count !== 4'(i)) begin
        n_err++; $display("FAIL fill_hold: count=%0d want %0d", count, i);
      end
      car_in = 1'b0;
      tick();
    end
    n_cmp++;
    if ({full, empty, free} !== {1'b1, 1'b0, 4'd0}) begin
      n_err++; $display("FAIL at_full: full=%b empty=%b free=%0d want 1 0 0", full, empty, free);
    end
    car_in = 1'b1;
    tick();
    car_in = 1'b0;
    tick();
    n_cmp++;
    if ({count, overflow_err} !== {4'd8, 1'b1}) begin
      n_err++; $display("FAIL overflow: count=%0d ovf=%b want 8 1", count, overflow_err);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_cmp++;
    if (overflow_err !== 1'b0) begin
      n_err++; $display("FAIL clear_ovf: ovf=%b want 0", overflow_err);
    end
  endtask

  task automatic test_simultaneous();
    car_in = 1'b1; car_out = 1'b1;
    tick();
    car_in = 1'b0; car_out = 1'b0;
    tick();
    n_cmp++;
    if ({count, overflow_err, underflow_err} !== {4'd8, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL simul_full: count=%0d ovf=%b unf=%b want 8 0 0",
                        count, overflow_err, underflow_err);
    end
    for (int i = 0; i < 8; i++) begin
      car_out = 1'b1; tick();
      car_out = 1'b0; tick();
    end
    n_cmp++;
    if ({count, empty, free} !== {4'd0, 1'b1, 4'd8}) begin
      n_err++; $display("FAIL drain: count=%0d empty=%b free=%0d want 0 1 8", count, empty, free);
    end
    car_in = 1'b1; car_out = 1'b1;
    tick();
    car_in = 1'b0; car_out = 1'b0;
    tick();
    n_cmp++;
    if ({count, underflow_err, overflow_err} !== {4'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL simul_empty: count=%0d unf=%b ovf=%b want 0 0 0",
                        count, underflow_err, overflow_err);
    end
    car_out = 1'b1; tick();
    car_out = 1'b0; tick();
    n_cmp++;
    if ({count, underflow_err} !== {4'd0, 1'b1}) begin
      n_err++; $display("FAIL underflow: count=%0d unf=%b want 0 1", count, underflow_err);
    end
    // New error in the same cycle as clear: error wins.
    car_out = 1'b1; clear_err = 1'b1;
    tick();
    car_out = 1'b0; clear_err = 1'b0;
    n_cmp++;
    if (underflow_err !== 1'b1) begin
      n_err++; $display("FAIL clear_vs_new: unf=%b want 1", underflow_err);
    end
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    n_cmp++;
    if (underflow_err !== 1'b0) begin
      n_err++; $display("FAIL clear_unf: unf=%b want 0", underflow_err);
    end
  endtask

  task automatic test_gate_entry();
    for (int i = 0; i < 3; i++) begin
      car_in = 1'b1; tick();
      car_in = 1'b0; tick();
    end
    entry_req = 1'b1;
    tick();
    n_cmp++;
    if ({gate_open, count} !== {1'b1, 4'd3}) begin
      n_err++; $display("FAIL gate_opens: gate=%b count=%0d want 1 3", gate_open, count);
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (gate_open !== 1'b1) begin
      n_err++; $display("FAIL gate_held: gate=%b want 1", gate_open);
    end
    car_in = 1'b1;
    tick();
    car_in = 1'b0;
    n_cmp++;
    if ({gate_open, count, gate_timeout} !== {1'b0, 4'd4, 1'b0}) begin
      n_err++; $display("FAIL car_enters: gate=%b count=%0d to=%b want 0 4 0",
                        gate_open, count, gate_timeout);
    end
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (gate_open || gate_timeout) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
        n_err++; $display("FAIL held_button: gate/timeout high %0d cycles want 0", seen);
      end
    end
    entry_req = 1'b0; tick();
    entry_req = 1'b1; tick();
    n_cmp++;
    if (gate_open !== 1'b1) begin
      n_err++; $display("FAIL reopen: gate=%b want 1", gate_open);
    end
    car_in = 1'b1; tick();
    car_in = 1'b0; entry_req = 1'b0; tick();
    n_cmp++;
    if ({gate_open, count} !== {1'b0, 4'd5}) begin
      n_err++; $display("FAIL second_entry: gate=%b count=%0d want 0 5", gate_open, count);
    end
  endtask

  task automatic test_timeout();
    int hi = 0;
    int pulses = 0;
    int guard = 0;
    logic to_at_close = 1'b0;
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    if (gate_open) hi++;
    while (gate_open === 1'b1 && guard < 300) begin
      tick();
      guard++;
      if (gate_open) hi++;
      if (gate_timeout) pulses++;
      if (gate_open !== 1'b1) to_at_close = gate_timeout;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gate_timeout) pulses++;
    end
    n_cmp++;
    if (hi !== 100) begin
      n_err++; $display("FAIL open_cycles: gate high %0d cycles want 100", hi);
    end
    n_cmp++;
    if ({pulses, to_at_close} !== {32'd1, 1'b1}) begin
      n_err++; $display("FAIL timeout_pulse: pulses=%0d at_close=%b want 1 1", pulses, to_at_close);
    end
    n_cmp++;
    if (count !== 4'd5) begin
      n_err++; $display("FAIL timeout_count: count=%0d want 5", count);
    end
  endtask

  task automatic test_full_gate();
    int opened = 0;
    for (int i = 0; i < 3; i++) begin
      car_in = 1'b1; tick();
      car_in = 1'b0; tick();
    end
    entry_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (gate_open) opened++;
    end
    entry_req = 1'b0;
    tick();
    n_cmp++;
    if ({full, opened} !== {1'b1, 32'd0}) begin
      n_err++; $display("FAIL full_gate: full=%b gate high %0d cycles want 1 0", full, opened);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      car_out = 1'b1; tick();
      car_out = 1'b0; tick();
    end
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    n_cmp++;
    if ({gate_open, count} !== {1'b1, 4'd5}) begin
      n_err++; $display("FAIL pre_reset: gate=%b count=%0d want 1 5", gate_open, count);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({count, free, empty, full, gate_open, gate_timeout}
        !== {4'd0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL async_reset: count=%0d free=%0d empty=%b full=%b gate=%b to=%b want 0 8 1 0 0 0",
                        count, free, empty, full, gate_open, gate_timeout);
    end
    tick();
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({count, gate_open} !== {4'd0, 1'b0}) begin
      n_err++; $display("FAIL post_reset: count=%0d gate=%b want 0 0", count, gate_open);
    end
  endtask

  initial begin
    reset = 1'b0;
    car_in = 0; car_out = 0; entry_req = 0; clear_err = 0;
    test_reset();
    test_fill();
    test_simultaneous();
    test_gate_entry();
    test_timeout();
    test_full_gate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
